// File: rtl/result_display_if.sv
// rtl/result_display_if.sv - producer/display handshake bundle for result_display
//
// Purpose: groups the value/valid/ready input handshake and the display outputs
// of result_display into one bundle.
// Signals:
//   value     producer -> display  unsigned binary value to show
//   in_valid  producer -> display  value is valid this cycle
//   in_ready  display -> producer  converter idle, can accept a value
//   done      display -> producer  one-cycle pulse, new display data valid
//   overflow  display -> producer  last accepted value >= 10^DIGITS
//   bcd       display -> producer  packed BCD, digit i at [4i+3:4i]
//   hex       display -> producer  active-low segments, display i at [7i+6:7i]
interface result_display_if #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
);
  logic [WIDTH-1:0]    value;
  logic                in_valid;
  logic                in_ready;
  logic                done;
  logic                overflow;
  logic [4*DIGITS-1:0] bcd;
  logic [7*DIGITS-1:0] hex;

  modport master (
    output value, in_valid,
    input  in_ready, done, overflow, bcd, hex
  );

  modport slave (
    input  value, in_valid,
    output in_ready, done, overflow, bcd, hex
  );
endinterface

// File: rtl/result_display.sv
// rtl/result_display.sv - binary to decimal seven-segment display driver
//
// Purpose: accepts an unsigned binary value over a valid/ready handshake,
// converts it to BCD with a one-bit-per-clock shift-and-add-3 engine and
// drives active-low seven-segment patterns, holding them until the next
// conversion completes.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    result_display_if slave: value/in_valid in; in_ready, done,
//          overflow, bcd, hex out
module result_display #(
  parameter int WIDTH         = 20,
  parameter int DIGITS        = 6,
  parameter int BLANK_LEADING = 1
) (
  input  logic           clk,
  input  logic           reset,
  result_display_if.slave bus
);

  // One extra internal digit so values >= 10^DIGITS can be detected.
  localparam int NBCD = 4 * (DIGITS + 1);
  localparam int CW   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDTH-1:0]    r_shreg;
  logic [NBCD-1:0]     r_bcd_int;
  logic [NBCD-1:0]     w_bcd_adj;
  logic [CW-1:0]       r_cnt;
  logic                r_done;
  logic                r_overflow;
  logic [4*DIGITS-1:0] r_bcd;
  logic [7*DIGITS-1:0] r_hex;
  logic [7*DIGITS-1:0] w_hex;
  logic                w_overflow;
  logic                w_lead_zero;
  logic                w_accept;
  logic                w_last_shift;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign w_accept     = (r_state == IDLE) && bus.in_valid;
  assign w_last_shift = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = SHIFT;
      SHIFT:   if (w_last_shift) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    w_bcd_adj = r_bcd_int;
    for (int i = 0; i <= DIGITS; i++) begin
      if (r_bcd_int[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd_int[4*i +: 4] + 4'd3;
      end
    end
  end

  // Segment patterns from the finished conversion; w_lead_zero tracks whether
  // the current digit and every digit above it are zero.
  always_comb begin
    w_overflow  = |r_bcd_int[4*DIGITS +: 4];
    w_hex       = '1;
    w_lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_lead_zero = w_lead_zero && (r_bcd_int[4*i +: 4] == 4'd0);
      if (w_overflow) begin
        w_hex[7*i +: 7] = 7'h3F;
      end else if ((BLANK_LEADING != 0) && (i != 0) && w_lead_zero) begin
        w_hex[7*i +: 7] = 7'h7F;
      end else begin
        w_hex[7*i +: 7] = seg7(r_bcd_int[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg    <= '0;
      r_bcd_int  <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_bcd      <= '0;
      r_hex      <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg   <= bus.value;
            r_bcd_int <= '0;
            r_cnt     <= '0;
          end
        end
        SHIFT: begin
          r_bcd_int <= {w_bcd_adj[NBCD-2:0], r_shreg[WIDTH-1]};
          r_shreg   <= r_shreg << 1;
          r_cnt     <= r_cnt + CW'(1);
        end
        DONE: begin
          r_bcd      <= r_bcd_int[4*DIGITS-1:0];
          r_overflow <= w_overflow;
          r_hex      <= w_hex;
          r_done     <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready = (r_state == IDLE);
  assign bus.done     = r_done;
  assign bus.overflow = r_overflow;
  assign bus.bcd      = r_bcd;
  assign bus.hex      = r_hex;

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - scoreboard bench for result_display
module tb_result_display;
  localparam int W = 20;
  localparam int D = 6;

  typedef struct {
    logic [4*D-1:0] bcd;
    logic [7*D-1:0] hex;
    logic           ovf;
    int             cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   tb_value = '0;
  logic           tb_valid = 1'b0;
  int             cyc = 0;
  int             n_cmp = 0;
  int             n_err = 0;
  exp_t           q_b[$];
  exp_t           q_n[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  result_display_if #(.WIDTH(W), .DIGITS(D)) bus_b ();
  result_display_if #(.WIDTH(W), .DIGITS(D)) bus_n ();

  assign bus_b.value    = tb_value;
  assign bus_b.in_valid = tb_valid;
  assign bus_n.value    = tb_value;
  assign bus_n.in_valid = tb_valid;

  result_display #(.WIDTH(W), .DIGITS(D), .BLANK_LEADING(1)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  result_display #(.WIDTH(W), .DIGITS(D), .BLANK_LEADING(0)) u_dut_n (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_n.slave)
  );

  function automatic logic [6:0] seg(input int d);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  // Reference: decimal digits by division; leading digit i is blank iff v < 10^i.
  function automatic exp_t model(input int unsigned v, input bit blank, input int c);
    exp_t        m;
    int unsigned p;
    int          d;
    p     = 1;
    m.ovf = (v >= 1000000);
    m.cyc = c;
    m.bcd = '0;
    m.hex = '0;
    for (int i = 0; i < D; i++) begin
      d = int'((v / p) % 10);
      m.bcd[4*i +: 4] = d[3:0];
      if (m.ovf)                         m.hex[7*i +: 7] = 7'h3F;
      else if (blank && i > 0 && v < p)  m.hex[7*i +: 7] = 7'h7F;
      else                               m.hex[7*i +: 7] = seg(d);
      p = p * 10;
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!reset && bus_b.done) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL blank_unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        e = q_b.pop_front();
        check("blank_bcd", 64'(bus_b.bcd), 64'(e.bcd));
        check("blank_hex", 64'(bus_b.hex), 64'(e.hex));
        check("blank_overflow", 64'(bus_b.overflow), 64'(e.ovf));
        check("blank_latency_cycle", 64'(cyc), 64'(e.cyc));
        check("blank_ready_with_done", 64'(bus_b.in_ready), 64'd1);
      end
    end
  end

  always @(negedge clk) begin : mon_n
    exp_t e;
    if (!reset && bus_n.done) begin
      if (q_n.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL noblank_unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        e = q_n.pop_front();
        check("noblank_bcd", 64'(bus_n.bcd), 64'(e.bcd));
        check("noblank_hex", 64'(bus_n.hex), 64'(e.hex));
        check("noblank_overflow", 64'(bus_n.overflow), 64'(e.ovf));
        check("noblank_latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int unsigned v, input bit keep);
    int guard;
    guard    = 0;
    tb_value = W'(v);
    tb_valid = 1'b1;
    while (!bus_b.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected 1", guard);
    end
    q_b.push_back(model(v, 1'b1, cyc + 22));
    q_n.push_back(model(v, 1'b0, cyc + 22));
    @(negedge clk);
    if (!keep) tb_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 64'(bus_b.in_ready), 64'd1);
    check({tag, "_done"},     64'(bus_b.done), 64'd0);
    check({tag, "_overflow"}, 64'(bus_b.overflow), 64'd0);
    check({tag, "_bcd"},      64'(bus_b.bcd), 64'd0);
    check({tag, "_hex"},      64'(bus_b.hex), 64'({D{7'h7F}}));
    check({tag, "_hex_nb"},   64'(bus_n.hex), 64'({D{7'h7F}}));
  endtask

  initial begin
    int unsigned v;
    int          guard;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    send(0, 1'b0);
    send(491520, 1'b0);
    send(1048575, 1'b0);
    send(1000, 1'b0);
    send(999999, 1'b0);
    send(1000000, 1'b0);
    send(100005, 1'b0);

    // Back-to-back: value wiggles while busy, 7 is taken on the done cycle.
    send(30, 1'b1);
    guard = 0;
    while (!bus_b.done && guard < 100) begin
      tb_value = W'($urandom_range(0, 20'hFFFFF));
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL b2b_done_timeout: got no done in %0d cycles expected 21", guard);
    end
    send(7, 1'b0);

    // Abort at the 10th shift edge.
    send(12345, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q_b.delete();
    q_n.delete();
    check_reset_state("abort");
    repeat (30) @(negedge clk);
    send(9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 999);
      else                            v = $urandom_range(0, 20'hFFFFF);
      send(v, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    guard = 0;
    while ((q_b.size() != 0 || q_n.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d results outstanding expected 0", q_b.size() + q_n.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Consumes the 20-bit arithmetic result produced by the lab ALU and drives it onto the board's active-low seven-segment displays as a decimal number.
- Conversion uses an iterative shift-and-add-3 (double-dabble) engine, one bit per clock, behind a valid/ready input handshake.
- Sits between the ALU output and the HEX display pins.
- Holds the last converted value on the displays until a new value is accepted.

Parameters:
- WIDTH, 20: width of the binary input value. Supported range is WIDTH ≤ 3*DIGITS+3.
- DIGITS, 6: number of decimal digits and seven-segment displays driven.
- BLANK_LEADING, 1: when 1, leading zero digits are blanked. Digit 0 is never blanked.

Ports:
- clk  input  1: system clock, rising-edge.
- reset  input  1: synchronous, active-high reset.
- value  input  WIDTH: unsigned binary value to display.
- in_valid  input  1: value is valid this cycle.
- in_ready  output  1: block can accept a value. Equals (state == IDLE).
- done  output  1: one-cycle pulse; new display data is valid.
- overflow  output  1: last accepted value ≥ 10^DIGITS.
- bcd  output  4*DIGITS: packed BCD of last value, low DIGITS digits. Digit i is at [4i+3:4i].
- hex  output  7*DIGITS: active-low segments. Display i is at [7i+6:7i], bit order {g,f,e,d,c,b,a}, bit 0 = a.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. reset has priority over all other inputs.
- Reset values:
  - state = IDLE, so in_ready = 1 after reset.
  - done = 0, overflow = 0, bcd = 0.
  - Every hex digit = 7'h7F (all segments off).
  - The shift register and internal BCD register (DIGITS+1 digits) are cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Accept occurs when in_valid && in_ready at a rising edge k.
  - On accept: value is captured into the shift register, the internal BCD register is cleared, the bit counter is cleared, and state goes to SHIFT.
  - Changes to value after edge k are ignored.
- SHIFT (edges k+1 .. k+WIDTH):
  - Each edge: every internal BCD digit ≥ 5 gets +3, then {bcd_int, shreg} shifts left by 1.
  - After WIDTH shifts, state goes to DONE.
- DONE (edge k+WIDTH+1):
  - bcd, overflow and hex are updated, done is set to 1, and state goes to IDLE.
  - done is high for exactly one cycle, coincident with in_ready returning high.
- Latency: accept to done-high is WIDTH+1 edges (21 for the default). in_ready is low for WIDTH+1 cycles after the accept edge.
- in_valid while busy is ignored and no value is captured. The producer must hold value and in_valid until accepted.
- Back-to-back transfers: a value presented while done is high is accepted that cycle with no bubble.
- overflow = 1 when the internal top digit (digit DIGITS) is nonzero after conversion. In that case every hex digit = 7'h3F (dash) and bcd holds the low DIGITS digits.
- Segment codes, digits 0–9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex). Blank = 7F, dash = 3F.
- Leading-zero blanking (BLANK_LEADING = 1): digit i (i ≥ 1) is blanked iff it and all higher digits are zero. Interior zeros are displayed.
- Reset mid-conversion: the conversion is aborted, done does not pulse, outputs return to reset values, and the next cycle is IDLE.
- Outputs are stable between done pulses. No combinational path from value to hex.

Test Plan:
- Reset, then value = 0 accepted:
  - done exactly 21 cycles after the accept edge.
  - bcd = 0x000000, hex[6:0] = 0x40, hex5..1 = 0x7F, overflow = 0.
- value = 491520 (15<<15):
  - bcd = 0x491520, overflow = 0.
  - hex5..0 = 19, 10, 79, 12, 24, 40.
- value = 1048575:
  - overflow = 1, bcd = 0x048575.
  - All six hex = 0x3F.
- value = 1000 with BLANK_LEADING = 1:
  - hex3..0 = 79, 40, 40, 40; hex5, 4 = 7F.
  - Rerun with BLANK_LEADING = 0: hex5, 4 = 40.
- in_valid held high with value = 30, switching to 7 on the cycle done is high:
  - Second value accepted that cycle; value changes during SHIFT are ignored.
  - First result bcd = 0x000030, second bcd = 0x000007 after 21 more cycles.
- reset asserted for 1 cycle at the 10th SHIFT edge of value = 12345:
  - No done pulse; hex all 7F, in_ready = 1 the next cycle.
  - A subsequent value = 9 displays hex0 = 0x10.
